// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Run controller for the parametrised CPU family. Sequences core
//            reset, runs the core until halt or a cycle-limit watchdog, and
//            records a per-cycle {pc, ir, halt} trace in a circular buffer
//            that can be drained after the run.
// Options  : RUN_CTRL_CHANGE_FILTER_EN - when defined, only cycles whose
//            {pc, ir} differs from the last recorded entry (or that carry
//            halt) are recorded; the first RUN cycle is always recorded.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int PC_W        = 8,
    parameter int IR_W        = 8,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 100,
    parameter int CNT_W       = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              cpu_halt,
    input  logic [PC_W-1:0]                   cpu_pc,
    input  logic [IR_W-1:0]                   cpu_ir,
    output logic                              cpu_rst,
    output logic                              running,
    output logic                              done,
    output logic                              timed_out,
    output logic [CNT_W-1:0]                  cycle_count,
    input  logic                              trace_rd_en,
    output logic [PC_W+IR_W:0]                trace_rd_data,
    output logic                              trace_empty,
    output logic [$clog2(TRACE_DEPTH+1)-1:0]  trace_count,
    output logic                              trace_overflow
);

    localparam int c_AW  = $clog2(TRACE_DEPTH);
    localparam int c_PW  = c_AW + 1;
    localparam int c_CW  = $clog2(TRACE_DEPTH + 1);
    localparam int c_TW  = PC_W + IR_W + 1;
    localparam int c_RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [c_RCW-1:0] c_RST_LAST = c_RCW'(RST_CYCLES - 1);
    localparam logic [c_PW-1:0]  c_FULL     = c_PW'(TRACE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_GRACE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_RCW-1:0]   r_rst_cnt;
    logic               r_cpu_rst;
    logic               r_running;
    logic               r_done;
    logic               r_timed_out;
    logic [CNT_W-1:0]   r_cycle_count;

    logic [c_TW-1:0]    r_mem [TRACE_DEPTH];
    logic [c_PW-1:0]    r_head;
    logic [c_PW-1:0]    r_tail;
    logic               r_overflow;

    logic               w_start_ok;
    logic               w_active;
    logic [CNT_W-1:0]   w_cc_next;
    logic [c_PW-1:0]    w_count;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [c_TW-1:0]    w_entry;

    // start is honoured only between runs; it is dropped in RESET/RUN/GRACE
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_active   = (r_state == S_RUN) || (r_state == S_GRACE);
    assign w_cc_next  = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 1'b1;

    // Pointers carry one extra bit so full and empty are distinguishable
    assign w_count = r_tail - r_head;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_FULL);
    assign w_pop   = trace_rd_en && !w_empty;
    assign w_entry = {cpu_pc, cpu_ir, cpu_halt};

`ifdef RUN_CTRL_CHANGE_FILTER_EN
    logic                  r_first;
    logic [PC_W+IR_W-1:0]  r_last;

    assign w_push = w_active && (r_first || ({cpu_pc, cpu_ir} != r_last) || cpu_halt);

    // Remember the last recorded {pc, ir}; re-arm the first-cycle push each run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b1;
            r_last  <= '0;
        end else if (w_start_ok) begin
            r_first <= 1'b1;
        end else if (w_push) begin
            r_first <= 1'b0;
            r_last  <= {cpu_pc, cpu_ir};
        end
    end
`else
    assign w_push = w_active;
`endif

    // Run sequencer with registered core reset, status flags and cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_cpu_rst     <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_cpu_rst <= 1'b1;
                    r_running <= 1'b0;
                    if (start) begin
                        r_state       <= S_RESET;
                        r_rst_cnt     <= '0;
                        r_done        <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state   <= S_RUN;
                        r_cpu_rst <= 1'b0;
                        r_running <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_cycle_count <= w_cc_next;
                    // halt takes priority over a coincident watchdog expiry
                    if (cpu_halt) begin
                        r_state   <= S_GRACE;
                        r_running <= 1'b0;
                    end else if (r_cycle_count == c_TO_LAST) begin
                        r_state     <= S_DONE;
                        r_running   <= 1'b0;
                        r_cpu_rst   <= 1'b1;
                        r_timed_out <= 1'b1;
                    end
                end
                S_GRACE: begin
                    r_cycle_count <= w_cc_next;
                    r_state       <= S_DONE;
                    r_done        <= 1'b1;
                    r_cpu_rst     <= 1'b1;
                    r_running     <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cpu_rst <= 1'b1;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Trace pointers: a push into a full buffer drops the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_overflow <= 1'b0;
        end else if (w_push) begin
            r_tail <= r_tail + 1'b1;
            if (w_pop || w_full) begin
                r_head <= r_head + 1'b1;
            end
            if (w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end else if (w_pop) begin
            r_head <= r_head + 1'b1;
        end
    end

    // Trace storage; a full push+pop overwrites the slot being popped this cycle
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail[c_AW-1:0]] <= w_entry;
        end
    end

    assign cpu_rst        = r_cpu_rst;
    assign running        = r_running;
    assign done           = r_done;
    assign timed_out      = r_timed_out;
    assign cycle_count    = r_cycle_count;
    assign trace_overflow = r_overflow;
    assign trace_empty    = w_empty;
    assign trace_count    = c_CW'(w_count);
    assign trace_rd_data  = w_empty ? '0 : r_mem[r_head[c_AW-1:0]];

endmodule
`default_nettype wire
